// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE    = 2'd0,
    LSU_ACCESS  = 2'd1,
    LSU_CAPTURE = 2'd2,
    LSU_RESP    = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response channel of the load/store unit.
interface lsu_if #(
  parameter int WORD_SIZE = 32
);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [31:0]          req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [WORD_SIZE-1:0] resp_rdata;
  logic                 resp_misaligned;
  logic                 resp_fault;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_fault
  );

endinterface

// File: rtl/lsu_align_check.sv
// Combinational alignment/range check and store-lane replication.
module lsu_align_check
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic [31:0]          addr,
  input  logic [1:0]           size,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 misaligned,
  output logic                 fault,
  output logic [WORD_SIZE-1:0] din
);

  // Memory writes lane k from din[8k+7:8k], so narrow data is copied to every lane.
  function automatic logic [WORD_SIZE-1:0] replicate_lanes(input logic [1:0] sz,
                                                           input logic [WORD_SIZE-1:0] wd);
    logic [WORD_SIZE-1:0] r;
    case (sz)
      SIZE_BYTE: r = {4{wd[7:0]}};
      SIZE_HALF: r = {2{wd[15:0]}};
      default:   r = wd;
    endcase
    return r;
  endfunction

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = addr[0];
      SIZE_WORD: misaligned = (addr[1:0] != 2'b00);
      default:   misaligned = 1'b1;
    endcase
  end

  assign fault = (addr >= 32'(MEM_BYTES));
  assign din   = replicate_lanes(size, wdata);

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request in flight, drives data memory Port B,
// waits out the registered read and holds the response until accepted.
module lsu
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  lsu_if.slave                 core,
  output logic                 mem_en_write,
  output logic                 mem_en_read,
  output logic [31:0]          mem_addr,
  output logic [WORD_SIZE-1:0] mem_din,
  output logic [1:0]           mem_size,
  output logic                 mem_unsigned,
  input  logic [WORD_SIZE-1:0] mem_dout
);

  lsu_state_e           state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [WORD_SIZE-1:0] din_q, din_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic                 write_q, write_d;
  logic                 mis_q, mis_d;
  logic                 flt_q, flt_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;

  logic                 chk_mis;
  logic                 chk_flt;
  logic [WORD_SIZE-1:0] chk_din;
  logic                 in_access;

  lsu_align_check #(
    .WORD_SIZE (WORD_SIZE),
    .MEM_BYTES (MEM_BYTES)
  ) u_align_check (
    .addr       (core.req_addr),
    .size       (core.req_size),
    .wdata      (core.req_wdata),
    .misaligned (chk_mis),
    .fault      (chk_flt),
    .din        (chk_din)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    size_d  = size_q;
    uns_d   = uns_q;
    write_d = write_q;
    mis_d   = mis_q;
    flt_d   = flt_q;
    rdata_d = rdata_q;
    case (state_q)
      LSU_IDLE: begin
        if (core.req_valid) begin
          addr_d  = core.req_addr;
          din_d   = chk_din;
          size_d  = core.req_size;
          uns_d   = core.req_unsigned;
          write_d = core.req_write;
          // Misalignment wins when both checks trip, so only one flag is raised.
          mis_d   = chk_mis;
          flt_d   = chk_flt & ~chk_mis;
          rdata_d = '0;
          state_d = (chk_mis || chk_flt) ? LSU_RESP : LSU_ACCESS;
        end
      end
      LSU_ACCESS:  state_d = write_q ? LSU_RESP : LSU_CAPTURE;
      LSU_CAPTURE: begin
        rdata_d = mem_dout;
        state_d = LSU_RESP;
      end
      LSU_RESP: begin
        if (core.resp_ready) begin
          mis_d   = 1'b0;
          flt_d   = 1'b0;
          rdata_d = '0;
          state_d = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      write_q <= write_d;
      mis_q   <= mis_d;
      flt_q   <= flt_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory port is driven only during ACCESS and is otherwise quiet.
  assign in_access    = (state_q == LSU_ACCESS);
  assign mem_en_write = in_access & write_q;
  assign mem_en_read  = in_access & ~write_q;
  assign mem_addr     = in_access ? addr_q : '0;
  assign mem_din      = in_access ? din_q : '0;
  assign mem_size     = in_access ? size_q : 2'b00;
  assign mem_unsigned = in_access & uns_q;

  assign core.req_ready       = (state_q == LSU_IDLE) & ~rst;
  assign core.resp_valid      = (state_q == LSU_RESP);
  assign core.resp_rdata      = rdata_q;
  assign core.resp_misaligned = mis_q;
  assign core.resp_fault      = flt_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a byte-addressed Port B memory model.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        mem_en_write;
  logic        mem_en_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_dout;

  lsu_if #(.WORD_SIZE(32)) bus ();

  lsu #(.WORD_SIZE(32), .MEM_BYTES(4096)) dut (
    .clk          (clk),
    .rst          (rst),
    .core         (bus),
    .mem_en_write (mem_en_write),
    .mem_en_read  (mem_en_read),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .mem_dout     (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port B model: lane-select writes, one-cycle registered extended read.
  logic [7:0]  mem [0:4095];
  logic [11:0] ma;
  assign ma = mem_addr[11:0];

  function automatic logic [31:0] rd_ext(input logic [11:0] a, input logic [1:0] sz, input logic un);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = {mem[{a[11:2], 2'd3}], mem[{a[11:2], 2'd2}], mem[{a[11:2], 2'd1}], mem[{a[11:2], 2'd0}]};
    b = w[int'(a[1:0]) * 8 +: 8];
    h = w[int'(a[1]) * 16 +: 16];
    case (sz)
      2'b00:   return un ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return un ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_en_write) begin
      case (mem_size)
        2'b00: mem[ma] <= mem_din[int'(ma[1:0]) * 8 +: 8];
        2'b01: begin
          mem[{ma[11:1], 1'b0}] <= mem_din[int'(ma[1]) * 16 +: 8];
          mem[{ma[11:1], 1'b1}] <= mem_din[int'(ma[1]) * 16 + 8 +: 8];
        end
        default: for (int k = 0; k < 4; k++) mem[{ma[11:2], k[1:0]}] <= mem_din[k * 8 +: 8];
      endcase
    end
    if (mem_en_read) mem_dout <= rd_ext(ma, mem_size, mem_unsigned);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Observations from the most recent transaction.
  int          r_lat, r_wr_cyc, r_rd_cyc, r_en_cnt;
  logic [31:0] r_rdata, r_din;
  logic [1:0]  r_msize;
  logic        r_mis, r_flt;

  // Issues one request and returns at the falling edge of the first RESP cycle.
  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic un);
    r_lat = 0; r_wr_cyc = 0; r_rd_cyc = 0; r_en_cnt = 0;
    r_rdata = 'x; r_din = 'x; r_msize = 'x; r_mis = 1'bx; r_flt = 1'bx;
    @(negedge clk);
    chk("req_ready_before", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (mem_en_write) begin
        r_en_cnt++; r_wr_cyc = cyc; r_din = mem_din; r_msize = mem_size;
      end
      if (mem_en_read) begin
        r_en_cnt++; r_rd_cyc = cyc; r_msize = mem_size;
      end
      if (bus.resp_valid) begin
        r_lat = cyc; r_rdata = bus.resp_rdata; r_mis = bus.resp_misaligned; r_flt = bus.resp_fault;
        break;
      end
      if (cyc > 1) chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    end
    if (r_lat == 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  // With resp_ready already high, RESP lasts one cycle and the unit is ready next cycle.
  task automatic finish_hs();
    @(posedge clk);
    @(negedge clk);
    chk("hs_resp_valid_low", 32'(bus.resp_valid), 32'd0);
    chk("hs_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic ok_resp(input string tag, input int lat, input logic [31:0] rdata);
    chk({tag, "_lat"}, 32'(r_lat), 32'(lat));
    chk({tag, "_rdata"}, r_rdata, rdata);
    chk({tag, "_mis"}, 32'(r_mis), 32'd0);
    chk({tag, "_flt"}, 32'(r_flt), 32'd0);
  endtask

  task automatic err_resp(input string tag, input logic mis, input logic flt);
    chk({tag, "_lat"}, 32'(r_lat), 32'd1);
    chk({tag, "_mis"}, 32'(r_mis), 32'(mis));
    chk({tag, "_flt"}, 32'(r_flt), 32'(flt));
    chk({tag, "_rdata"}, r_rdata, 32'd0);
    chk({tag, "_mem_en"}, 32'(r_en_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_flags", {30'd0, bus.resp_misaligned, bus.resp_fault}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_en", {30'd0, mem_en_write, mem_en_read}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;

    // Word store then load back.
    run_txn(1'b1, 32'h10, 32'hCAFEBABE, 2'b10, 1'b0);
    ok_resp("st_w", 2, 32'd0);
    chk("st_w_wr_cyc", 32'(r_wr_cyc), 32'd1);
    chk("st_w_din", r_din, 32'hCAFEBABE);
    chk("st_w_size", 32'(r_msize), 32'd2);
    finish_hs();
    run_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    ok_resp("ld_w", 3, 32'hCAFEBABE);
    chk("ld_w_rd_cyc", 32'(r_rd_cyc), 32'd1);
    chk("ld_w_en_cnt", 32'(r_en_cnt), 32'd1);
    finish_hs();

    // Byte and half stores into a known word, then narrow and full loads.
    run_txn(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0);
    finish_hs();
    run_txn(1'b1, 32'h21, 32'h123456A5, 2'b00, 1'b0);
    ok_resp("st_b", 2, 32'd0);
    chk("st_b_din", r_din, 32'hA5A5A5A5);
    chk("st_b_size", 32'(r_msize), 32'd0);
    finish_hs();
    run_txn(1'b0, 32'h21, 32'h0, 2'b00, 1'b0);
    ok_resp("ld_b_s", 3, 32'hFFFFFFA5);
    finish_hs();
    run_txn(1'b0, 32'h21, 32'h0, 2'b00, 1'b1);
    ok_resp("ld_b_u", 3, 32'h000000A5);
    finish_hs();
    run_txn(1'b1, 32'h22, 32'h7777BEEF, 2'b01, 1'b0);
    chk("st_h_din", r_din, 32'hBEEFBEEF);
    chk("st_h_size", 32'(r_msize), 32'd1);
    finish_hs();
    run_txn(1'b0, 32'h22, 32'h0, 2'b01, 1'b1);
    ok_resp("ld_h_u", 3, 32'h0000BEEF);
    finish_hs();
    run_txn(1'b0, 32'h22, 32'h0, 2'b01, 1'b0);
    ok_resp("ld_h_s", 3, 32'hFFFFBEEF);
    finish_hs();
    run_txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    ok_resp("ld_w_mix", 3, 32'hBEEFA544);
    finish_hs();

    // Error paths never touch memory.
    run_txn(1'b0, 32'h13, 32'h0, 2'b01, 1'b0);
    err_resp("mis_half", 1'b1, 1'b0);
    finish_hs();
    run_txn(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0);
    err_resp("fault_w", 1'b0, 1'b1);
    finish_hs();
    run_txn(1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
    err_resp("size11", 1'b1, 1'b0);
    finish_hs();
    run_txn(1'b1, 32'h1001, 32'h55, 2'b10, 1'b0);
    err_resp("mis_and_fault", 1'b1, 1'b0);
    finish_hs();
    run_txn(1'b1, 32'h2, 32'h0, 2'b10, 1'b0);
    err_resp("mis_word", 1'b1, 1'b0);
    finish_hs();

    // Last byte in range is legal.
    run_txn(1'b1, 32'hFFF, 32'h5A, 2'b00, 1'b0);
    ok_resp("st_top", 2, 32'd0);
    finish_hs();
    run_txn(1'b0, 32'hFFF, 32'h0, 2'b00, 1'b1);
    ok_resp("ld_top", 3, 32'h0000005A);
    finish_hs();

    // Response held under back-pressure.
    bus.resp_ready = 1'b0;
    run_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    ok_resp("stall", 3, 32'hCAFEBABE);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(bus.resp_valid), 32'd1);
      chk("stall_rdata", bus.resp_rdata, 32'hCAFEBABE);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    finish_hs();

    // Reset while a load is in ACCESS.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10;
    bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_access_rd", 32'(mem_en_read), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort_mem_en", {30'd0, mem_en_write, mem_en_read}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_ctl", {29'd0, mem_size, mem_unsigned}, 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    run_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    ok_resp("post_rst", 3, 32'hCAFEBABE);
    finish_hs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the data memory's Port B. Accepts one load or store request at a time, checks alignment and range, and replicates store data across byte lanes. It drives the memory's write/read enables, size and sign controls, waits out the memory's one-cycle registered read, and returns a held response to the core. Misaligned and out-of-range requests complete with an error flag and never touch memory.

## Interface
- `WORD_SIZE`, 32: data width; only 32 is supported.
- `MEM_BYTES`, 4096: size of the data memory in bytes; addresses at or above this value fault.

Ports (clock and reset first):
- `clk`  in  1  sole clock; every register updates on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  load zero-extends when 1.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  core accepts the response.
- `resp_rdata`  out  32  load data, already extended by memory.
- `resp_misaligned`  out  1  request misaligned or illegal size.
- `resp_fault`  out  1  address out of range.
- `mem_en_write`  out  1  to memory Port B write enable.
- `mem_en_read`  out  1  to memory Port B read enable.
- `mem_addr`  out  32  to memory Port B address.
- `mem_din`  out  32  lane-replicated store data.
- `mem_size`  out  2  to memory Port B size.
- `mem_unsigned`  out  1  to memory Port B sign control.
- `mem_dout`  in  32  from memory Port B; valid the cycle after the read enable.

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, register addr, wdata, size, unsigned and write, plus the check results.
  - Misaligned or fault → RESP.
  - Otherwise → ACCESS.
- Misaligned conditions:
  - size 01 with addr[0]=1.
  - size 10 with addr[1:0]≠0.
  - size 11.
- Fault condition: addr ≥ `MEM_BYTES`. Misaligned takes priority if both conditions hold; only one flag is set.
- ACCESS: lasts exactly one cycle.
  - `mem_en_write` = registered write; `mem_en_read` = not registered write.
  - `mem_addr`, `mem_size` and `mem_unsigned` come from registers.
  - A store goes → RESP; a load goes → CAPTURE.
- CAPTURE: register `mem_dout` into the `resp_rdata` register, then → RESP. Memory enables are 0.
- RESP: `resp_valid`=1 and all response outputs are held stable. When `resp_ready`=1, go → IDLE.
- Memory enables are 0 in every state except ACCESS.
- Lane replication of `mem_din` (memory writes lane k from din bits [8k+7:8k]):
  - byte → {4{wdata[7:0]}}.
  - half → {2{wdata[15:0]}}.
  - word → wdata.
- For stores and errored requests, `resp_rdata` = 0.

## Timing
- A load accepted at edge N:
  - ACCESS in cycle N+1 (enables high).
  - The memory word is registered at edge N+2, so `mem_dout` is valid in cycle N+2 (CAPTURE).
  - `resp_valid` rises in cycle N+3.
- A store accepted at edge N: write committed at edge N+2; `resp_valid` in cycle N+2.
- An errored request accepted at edge N: `resp_valid` in cycle N+1, with no memory activity.
- `req_ready` is 0 from acceptance until the edge on which the response is accepted, so there is no back-to-back overlap. The earliest next acceptance is the cycle after the RESP handshake.
- Reset:
  - While `rst`=1 all registers clear and state goes to IDLE.
  - `resp_valid`, the error flags, `resp_rdata` and all `mem_*` outputs are 0. `req_ready` is 0 while `rst`=1.
  - A request pending during reset is dropped. Reset during ACCESS aborts it at that edge; a write whose enable is high on the reset edge may still commit in memory, and this is allowed.
- `resp_ready` held 1 in advance: RESP still lasts one cycle.

## Structure
- Package `lsu_pkg` holds:
  - Size encodings: `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`.
  - State encoding: `LSU_IDLE`, `LSU_ACCESS`, `LSU_CAPTURE`, `LSU_RESP`.
- Sub-module `lsu_align_check` is purely combinational. It takes addr and size, produces misaligned, fault and replicated din, and is reused later by the instruction fetch path.
- Top `lsu` holds the FSM and the request/response registers.

## Test plan
- Store word 0xCAFEBABE @0x10, then load word @0x10 → `mem_en_write` pulse in cycle N+1; the load returns 0xCAFEBABE with `resp_valid` in cycle N+3.
- Store byte 0xA5 @0x21 → `mem_din`=0xA5A5A5A5, `mem_size`=00. Signed byte load @0x21 → 0xFFFFFFA5; unsigned → 0x000000A5.
- Half load @0x13 → `resp_misaligned`=1 in cycle N+1. Both enables stay 0 throughout; `resp_rdata`=0.
- Word load @0x1000 with `MEM_BYTES`=4096 → `resp_fault`=1 and no memory access. Size 11 @0x0 → `resp_misaligned`=1.
- Load with `resp_ready` held 0 for 5 cycles → `resp_valid` and data stable for all 5; `req_ready`=0 until the handshake, then 1 in the next cycle.
- `rst` asserted during ACCESS of a load → next cycle shows state IDLE, `resp_valid`=0 and all `mem_*`=0; after release a fresh load completes normally.
